// File: rtl/tau_pkg.sv
// Shared types and default widths for the tau datapath.
package tau_pkg;

  localparam int unsigned TauAddrW = 8;
  localparam int unsigned TauDataW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StHalted,
    StFault
  } pc_seq_state_t;

endpackage

// File: rtl/counter_loadable.sv
// Loadable up-counter with async active-high reset; load wins over count.
module counter_loadable #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (enable) begin
      if (load) begin
        value_q <= load_value;
      end else if (count) begin
        value_q <= value_q + WIDTH'(1);
      end
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the tau program counter.
// Optional fetch watchdog enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer
  import tau_pkg::*;
#(
  parameter int unsigned ADDR_W  = TauAddrW,
  parameter int unsigned DATA_W  = TauDataW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  pc_seq_state_t     state_q, state_d;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              timeout_hit;
  logic              start_ok, ack_ok, retire;
  logic              cnt_load, cnt_count;
  logic [ADDR_W-1:0] cnt_load_value;

  // Qualified events: each only counts in its own state with enable high.
  assign start_ok = enable && start && (state_q == StIdle || state_q == StHalted);
  assign ack_ok   = enable && mem_ack && (state_q == StFetch);
  assign retire   = enable && exec_done && (state_q == StExec);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHalted: if (start) state_d = StFetch;
      StFetch: begin
        if (mem_ack) begin
          state_d = StExec;
        end else if (timeout_hit) begin
          state_d = StFault;
        end
      end
      StExec:  if (exec_done) state_d = halt ? StHalted : StFetch;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    busy    = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = enable;
        busy    = 1'b1;
      end
      StExec:  busy = 1'b1;
`ifdef PC_SEQ_TIMEOUT_EN
      StFault: fault = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  logic [WdogW-1:0] wdog_q;

  // Cleared whenever outside FETCH so every fetch starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (enable) begin
      if (state_q != StFetch) begin
        wdog_q <= '0;
      end else if (!mem_ack) begin
        wdog_q <= wdog_q + WdogW'(1);
      end
    end
  end

  assign timeout_hit = (state_q == StFetch) && !mem_ack && (wdog_q == WdogW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else if (enable) begin
      if (ack_ok) begin
        instr_q <= mem_rdata;
      end
      instr_valid_q <= ack_ok;
    end
  end

  assign cnt_load       = start_ok || (retire && branch_taken);
  assign cnt_count      = retire && !branch_taken;
  assign cnt_load_value = (state_q == StExec) ? branch_target : start_addr;

  counter_loadable #(
    .WIDTH (ADDR_W)
  ) u_pc_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .count      (cnt_count),
    .value      (pc)
  );

  assign mem_addr    = pc;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (watchdog steps under PC_SEQ_TIMEOUT_EN).
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        start;
  logic [7:0]  start_addr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halt;
  logic [7:0]  pc;
  logic        busy;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .start_addr    (start_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .pc            (pc),
    .busy          (busy),
    .fault         (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One fetch with immediate ack followed by a one-cycle execute.
  task automatic run_instr(input logic [15:0] data, input logic br, input logic [7:0] tgt,
                           input logic hlt, input logic [7:0] exp_addr,
                           input logic [7:0] exp_next);
    check("fetch_req", 32'(mem_req), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'(exp_addr));
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack = 1'b0;
    check("instr", 32'(instr), 32'(data));
    check("instr_valid_hi", 32'(instr_valid), 32'd1);
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;
    tick();
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
    check("next_pc", 32'(pc), 32'(exp_next));
    check("instr_valid_lo", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    start         = 1'b0;
    start_addr    = 8'h00;
    mem_ack       = 1'b0;
    mem_rdata     = 16'h0000;
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    halt          = 1'b0;
    #12;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // Start at 0x10, immediate ack, one idle EXEC cycle before exec_done.
    start      = 1'b1;
    start_addr = 8'h10;
    tick();
    start = 1'b0;
    check("start_pc", 32'(pc), 32'h10);
    check("start_req", 32'(mem_req), 32'd1);
    check("start_addr", 32'(mem_addr), 32'h10);
    check("start_busy", 32'(busy), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 16'hA001;
    tick();
    mem_ack = 1'b0;
    check("first_instr", 32'(instr), 32'hA001);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("exec_no_req", 32'(mem_req), 32'd0);
    tick();
    check("valid_pulse_end", 32'(instr_valid), 32'd0);
    check("exec_wait_pc", 32'(pc), 32'h10);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("seq_pc_11", 32'(pc), 32'h11);

    // Sequential run, branch, wrap and halt.
    run_instr(16'hB002, 1'b0, 8'h00, 1'b0, 8'h11, 8'h12);
    run_instr(16'hB003, 1'b0, 8'h00, 1'b0, 8'h12, 8'h13);
    run_instr(16'hC004, 1'b1, 8'hDE, 1'b0, 8'h13, 8'hDE);
    run_instr(16'hC005, 1'b0, 8'h00, 1'b0, 8'hDE, 8'hDF);
    run_instr(16'hD006, 1'b1, 8'hFF, 1'b0, 8'hDF, 8'hFF);
    run_instr(16'hD007, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00);
    run_instr(16'hE008, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_req", 32'(mem_req), 32'd0);

    // exec_done / mem_ack ignored while halted.
    exec_done     = 1'b1;
    mem_ack       = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h55;
    tick();
    exec_done    = 1'b0;
    mem_ack      = 1'b0;
    branch_taken = 1'b0;
    check("halt_hold_pc", 32'(pc), 32'h01);
    check("halt_hold_busy", 32'(busy), 32'd0);

    start      = 1'b1;
    start_addr = 8'h40;
    tick();
    start = 1'b0;
    check("restart_pc", 32'(pc), 32'h40);
    check("restart_req", 32'(mem_req), 32'd1);

    // Freeze during FETCH with ack and start pulsed.
    enable    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    start     = 1'b1;
    start_addr = 8'h77;
    #1;
    check("frozen_req", 32'(mem_req), 32'd0);
    tick();
    tick();
    check("frozen_pc", 32'(pc), 32'h40);
    check("frozen_instr", 32'(instr), 32'hE008);
    check("frozen_valid", 32'(instr_valid), 32'd0);
    check("frozen_busy", 32'(busy), 32'd1);
    mem_ack = 1'b0;
    enable  = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_start_ignored", 32'(pc), 32'h40);
    tick();
    run_instr(16'hF009, 1'b0, 8'h00, 1'b0, 8'h40, 8'h41);

    // Asynchronous reset in the middle of a fetch.
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_pc", 32'(pc), 32'h0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_instr", 32'(instr), 32'h0);
    reset = 1'b0;
    check("fault_low", 32'(fault), 32'd0);

`ifdef PC_SEQ_TIMEOUT_EN
    start      = 1'b1;
    start_addr = 8'h20;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("wdog_not_yet", 32'(fault), 32'd0);
    check("wdog_still_req", 32'(mem_req), 32'd1);
    tick();
    check("wdog_fault", 32'(fault), 32'd1);
    check("wdog_req_off", 32'(mem_req), 32'd0);
    check("wdog_pc", 32'(pc), 32'h20);
    start      = 1'b1;
    start_addr = 8'h30;
    mem_ack    = 1'b1;
    tick();
    start   = 1'b0;
    mem_ack = 1'b0;
    check("fault_held", 32'(fault), 32'd1);
    check("fault_pc_held", 32'(pc), 32'h20);
    reset = 1'b1;
    #1;
    check("fault_cleared", 32'(fault), 32'd0);
    check("fault_rst_pc", 32'(pc), 32'h0);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute sequencer that owns the program counter for the tau datapath.
- Drives an internal counter_loadable instance for the PC: count = sequential advance, load = start/branch target.
- Runs a request/acknowledge instruction-fetch handshake with instruction memory, presents the fetched word to decode, and waits for the datapath to report execution complete.

Parameters:
- ADDR_W, 8, width of PC / fetch address (word-addressed, advance step 1).
- DATA_W, 16, instruction word width.
- TIMEOUT, 15, fetch watchdog limit in cycles (used only with PC_SEQ_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global advance enable; low freezes FSM, PC and all registered outputs.
- start  in  1  in IDLE/HALTED: load start_addr and begin fetching.
- start_addr  in  ADDR_W  initial PC.
- mem_req  out  1  fetch request; high only in FETCH with enable high.
- mem_addr  out  ADDR_W  fetch address, equals pc.
- mem_ack  in  1  memory response strobe; honoured only when mem_req high.
- mem_rdata  in  DATA_W  instruction word, valid with mem_ack.
- instr  out  DATA_W  latched instruction.
- instr_valid  out  1  one-cycle pulse in the cycle after the accepted ack.
- exec_done  in  1  datapath finished current instruction.
- branch_taken  in  1  sampled with exec_done: redirect PC.
- branch_target  in  ADDR_W  new PC when branch_taken.
- halt  in  1  sampled with exec_done: stop after this instruction.
- pc  out  ADDR_W  current program counter (counter_value).
- busy  out  1  high in FETCH or EXEC.
- fault  out  1  watchdog fault flag (constant 0 without PC_SEQ_TIMEOUT_EN).

Behaviour:
- Reset (async): state=IDLE, pc=0, instr=0, instr_valid=0, mem_req=0, busy=0, fault=0.
- States: IDLE, FETCH, EXEC, HALTED (+ FAULT with the optional feature).
- All transitions and PC updates require enable=1; with enable=0 the state and all registers hold, mem_req=0, and mem_ack is ignored.
- IDLE/HALTED + start: counter load=1 with start_addr; next state FETCH. pc updates on the same edge.
- FETCH: mem_req=1, mem_addr=pc. On mem_ack: instr<=mem_rdata and state<=EXEC on the same edge; instr_valid=1 for exactly the first EXEC cycle.
- EXEC: wait for exec_done. On exec_done:
  - branch_taken=1: load branch_target.
  - branch_taken=0: count (pc+1).
  - halt=1: next state HALTED, else FETCH.
  - halt is applied after the PC update, so pc reflects the next instruction when halted.
- exec_done asserted in the same cycle as instr_valid is legal (one-cycle execute).
- Wrap-around: pc+1 from 2^ADDR_W-1 gives 0; no flag.
- load and count are mutually exclusive by construction; the counter's enable is tied to the sequencer's enable.
- start, exec_done and mem_ack outside their respective states are ignored.
- Reset mid-fetch drops mem_req asynchronously; memory must discard the outstanding request.
- Minimum instruction period: 2 cycles (FETCH with immediate ack, EXEC with immediate exec_done).

Optional Feature:
- Macro PC_SEQ_TIMEOUT_EN. When defined:
  - a watchdog counter is cleared on FETCH entry and increments on each enabled FETCH cycle without mem_ack;
  - reaching TIMEOUT moves the FSM to FAULT: mem_req=0, fault=1, pc held;
  - only reset leaves FAULT.
- When not defined: no watchdog logic, FETCH waits indefinitely, fault tied to 0.

Decomposition:
- Shared package tau_pkg: state enum pc_seq_state_t, default widths (ADDR_W, DATA_W).
- Sub-module: reuse the existing counter_loadable (WIDTH=ADDR_W) for the PC; no new sub-module.

Test Plan:
- Reset, then start with start_addr=0x10, ack immediately -> pc=0x10, mem_req in the cycle after start, instr=mem_rdata, instr_valid single pulse.
- Three sequential instructions from 0x10, exec_done with no branch -> mem_addr sequence 0x10, 0x11, 0x12; pc=0x13 after the third.
- exec_done with branch_taken and branch_target=0xDE -> next mem_addr=0xDE; then no branch -> 0xDF.
- pc=0xFF, sequential exec_done -> pc wraps to 0x00; halt with exec_done -> HALTED, busy=0, mem_req=0; start resumes at start_addr.
- enable=0 during FETCH with mem_ack pulsed -> mem_req=0, ack ignored, state/pc unchanged; enable=1 and delayed ack -> normal accept.
- (PC_SEQ_TIMEOUT_EN, TIMEOUT=4) no ack for 4 enabled FETCH cycles -> fault=1, FAULT held; reset clears fault and sets pc=0.
